// File: rtl/cert_chain_sequencer_pkg.sv
// Shared definitions for the certificate chain sequencer: FSM state encoding,
// result codes, slot encodings shared with the comparator and per-slot chain lengths.
// Latency: n/a (definitions only). Backpressure: n/a.
package cert_chain_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_PULSE = 3'd2,
        ST_CHECK = 3'd3,
        ST_GAP   = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    // Slot encodings as seen by the comparator; slot 3 carries no chain.
    localparam logic [1:0] SLOT_0    = 2'd0;
    localparam logic [1:0] SLOT_1    = 2'd1;
    localparam logic [1:0] SLOT_2    = 2'd2;
    localparam logic [1:0] SLOT_NONE = 2'd3;

    localparam logic [7:0] SLOT0_CHAIN_LEN = 8'd6;
    localparam logic [7:0] SLOT1_CHAIN_LEN = 8'd4;
    localparam logic [7:0] SLOT2_CHAIN_LEN = 8'd5;

    localparam logic [2:0] ERR_OK       = 3'd0;
    localparam logic [2:0] ERR_BAD_SLOT = 3'd1;
    localparam logic [2:0] ERR_MISMATCH = 3'd2;
    localparam logic [2:0] ERR_ABORT    = 3'd3;
    localparam logic [2:0] ERR_TIMEOUT  = 3'd4;

    // Zero length marks a slot that cannot be verified.
    function automatic logic [7:0] chain_len(input logic [1:0] slot);
        logic [7:0] len;
        len = 8'd0;
        case (slot)
            SLOT_0:  len = SLOT0_CHAIN_LEN;
            SLOT_1:  len = SLOT1_CHAIN_LEN;
            SLOT_2:  len = SLOT2_CHAIN_LEN;
            default: len = 8'd0;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/cert_chain_sequencer_if.sv
// Chunk stream (valid/ready) plus comparator bus between the sequencer and its neighbours.
// Latency: n/a (wiring only). Backpressure: Cert_ready from the sequencer stalls the chunk source.
// Modports: master = sequencer side, slave = receive path + comparator side.
interface cert_chain_sequencer_if #(
    parameter int PAYLOAD_W = 256
) ();
    logic                 Cert_valid;
    logic                 Cert_ready;
    logic [PAYLOAD_W-1:0] Cert_payload;
    logic                 Cmp_enable;
    logic [1:0]           Cmp_slot;
    logic [7:0]           Cmp_counter;
    logic [PAYLOAD_W-1:0] Cmp_payload;
    logic                 Cmp_valid;
    logic                 Cmp_error;

    modport master (
        input  Cert_valid, Cert_payload, Cmp_valid, Cmp_error,
        output Cert_ready, Cmp_enable, Cmp_slot, Cmp_counter, Cmp_payload
    );

    modport slave (
        output Cert_valid, Cert_payload, Cmp_valid, Cmp_error,
        input  Cert_ready, Cmp_enable, Cmp_slot, Cmp_counter, Cmp_payload
    );
endinterface

// File: rtl/cert_chain_sequencer_timer.sv
// cert_seq_timer: counts consecutive idle WAIT cycles; built only with CERT_SEQ_TIMEOUT_EN.
// Latency: expired is combinational, high during the TIMEOUT_CYCLES-th consecutive run cycle.
// Backpressure: none; clear (a chunk transfer) or leaving run restarts the count.
`ifdef CERT_SEQ_TIMEOUT_EN
module cert_seq_timer #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic Reset_n,
    input  logic run,
    input  logic clear,
    output logic expired
);
    localparam logic [15:0] LAST_CNT = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] idle_cnt;

    // idle_cnt holds the number of run cycles already seen, so the current
    // cycle is number idle_cnt+1.
    assign expired = run && (idle_cnt == LAST_CNT);

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            idle_cnt <= 16'd0;
        end else if (clear || !run) begin
            idle_cnt <= 16'd0;
        end else if (!expired) begin
            idle_cnt <= idle_cnt + 16'd1;
        end
    end
endmodule
`endif

// File: rtl/cert_chain_sequencer.sv
// Steps the certificate comparator through one slot chain, one pulse per buffered chunk, and reports pass/fail.
// Latency: chunk transfer -> Cmp_enable next cycle; verdict sampled one cycle later; Done one cycle after the DONE state.
// Backpressure: Cert_ready is high only in WAIT; one chunk in flight, no queueing of Start.
// Ports: clk, Reset_n (async active-low), Start/Abort/Slot_in control, bus (chunk stream + comparator),
// Busy/Done/Pass/Err_code status. Optional idle timeout enabled by defining CERT_SEQ_TIMEOUT_EN.
module cert_chain_sequencer
    import cert_chain_sequencer_pkg::*;
#(
    parameter int PAYLOAD_W      = 256,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                      clk,
    input  logic                      Reset_n,
    input  logic                      Start,
    input  logic                      Abort,
    input  logic [1:0]                Slot_in,
    cert_chain_sequencer_if.master    bus,
    output logic                      Busy,
    output logic                      Done,
    output logic                      Pass,
    output logic [2:0]                Err_code
);
    state_t               state;
    logic [1:0]           slot_q;
    logic [7:0]           chain_n;
    logic [7:0]           index;
    logic [PAYLOAD_W-1:0] payload_buf;
    logic                 cert_ready_q;
    logic                 cmp_enable_q;
    logic [7:0]           cmp_counter_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 pass_q;
    logic [2:0]           err_q;
    logic                 xfer;
    logic                 timeout_hit;

    assign xfer = bus.Cert_valid & cert_ready_q;

`ifdef CERT_SEQ_TIMEOUT_EN
    cert_seq_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .Reset_n (Reset_n),
        .run     (state == ST_WAIT),
        .clear   (xfer),
        .expired (timeout_hit)
    );
`else
    logic [31:0] unused_timeout_cfg;
    assign unused_timeout_cfg = TIMEOUT_CYCLES;
    assign timeout_hit        = 1'b0;
`endif

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state         <= ST_IDLE;
            slot_q        <= 2'd0;
            chain_n       <= 8'd0;
            index         <= 8'd0;
            payload_buf   <= '0;
            cert_ready_q  <= 1'b0;
            cmp_enable_q  <= 1'b0;
            cmp_counter_q <= 8'd0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            err_q         <= ERR_OK;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (Start) begin
                        slot_q <= Slot_in;
                        busy_q <= 1'b1;
                        pass_q <= 1'b0;
                        err_q  <= ERR_OK;
                        if (chain_len(Slot_in) == 8'd0) begin
                            err_q <= ERR_BAD_SLOT;
                            state <= ST_DONE;
                        end else begin
                            chain_n      <= chain_len(Slot_in);
                            index        <= 8'd1;
                            cert_ready_q <= 1'b1;
                            state        <= ST_WAIT;
                        end
                    end
                end
                // Abort outranks a transfer in the same cycle: the chunk is dropped.
                ST_WAIT: begin
                    if (Abort) begin
                        cert_ready_q <= 1'b0;
                        err_q        <= ERR_ABORT;
                        state        <= ST_DONE;
                    end else if (xfer) begin
                        payload_buf   <= bus.Cert_payload;
                        cert_ready_q  <= 1'b0;
                        cmp_enable_q  <= 1'b1;
                        cmp_counter_q <= index;
                        state         <= ST_PULSE;
                    end else if (timeout_hit) begin
                        cert_ready_q <= 1'b0;
                        err_q        <= ERR_TIMEOUT;
                        state        <= ST_DONE;
                    end
                end
                ST_PULSE: begin
                    cmp_enable_q <= 1'b0;
                    if (Abort) begin
                        err_q <= ERR_ABORT;
                        state <= ST_DONE;
                    end else begin
                        state <= ST_CHECK;
                    end
                end
                // Comparator flags reflect the pulse of the previous cycle.
                ST_CHECK: begin
                    if (Abort) begin
                        err_q <= ERR_ABORT;
                        state <= ST_DONE;
                    end else if (bus.Cmp_error || !bus.Cmp_valid) begin
                        err_q <= ERR_MISMATCH;
                        state <= ST_DONE;
                    end else if (index == chain_n) begin
                        pass_q <= 1'b1;
                        state  <= ST_DONE;
                    end else begin
                        index <= index + 8'd1;
                        state <= ST_GAP;
                    end
                end
                // Idle cycle so the comparator flags clear before the next pulse.
                ST_GAP: begin
                    if (Abort) begin
                        err_q <= ERR_ABORT;
                        state <= ST_DONE;
                    end else begin
                        cert_ready_q <= 1'b1;
                        state        <= ST_WAIT;
                    end
                end
                ST_DONE: begin
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.Cert_ready  = cert_ready_q;
    // Masked combinationally so an Abort during PULSE removes the enable in that same cycle.
    assign bus.Cmp_enable  = cmp_enable_q & ~Abort;
    assign bus.Cmp_slot    = slot_q;
    assign bus.Cmp_counter = cmp_counter_q;
    assign bus.Cmp_payload = payload_buf;
    assign Busy            = busy_q;
    assign Done            = done_q;
    assign Pass            = pass_q;
    assign Err_code        = err_q;
endmodule

// File: tb/tb_cert_chain_sequencer.sv
// Directed bench for cert_chain_sequencer with a behavioural comparator and
// scoreboard queues for comparator pulses and chain results.
module tb_cert_chain_sequencer;
    import cert_chain_sequencer_pkg::*;

    localparam int PW = 32;
    localparam int TO = 8;

    typedef struct packed {
        logic [1:0]  slot;
        logic [7:0]  idx;
        logic [31:0] payload;
    } pulse_t;

    typedef struct packed {
        logic       pass;
        logic [2:0] err;
    } result_t;

    logic       clk = 1'b0;
    logic       Reset_n;
    logic       Start;
    logic       Abort;
    logic [1:0] Slot_in;
    logic       Busy;
    logic       Done;
    logic       Pass;
    logic [2:0] Err_code;

    cert_chain_sequencer_if #(.PAYLOAD_W(PW)) bus ();

    cert_chain_sequencer #(
        .PAYLOAD_W      (PW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk      (clk),
        .Reset_n  (Reset_n),
        .Start    (Start),
        .Abort    (Abort),
        .Slot_in  (Slot_in),
        .bus      (bus.master),
        .Busy     (Busy),
        .Done     (Done),
        .Pass     (Pass),
        .Err_code (Err_code)
    );

    always #5 clk = ~clk;

    pulse_t  pulse_q[$];
    result_t result_q[$];
    pulse_t  exp_p;
    result_t exp_r;
    int cmp_cnt = 0;
    int mis_cnt = 0;
    int pulse_cnt = 0;
    int done_cnt = 0;
    int ready_cycles = 0;

    function automatic logic [31:0] golden(input logic [1:0] s, input logic [7:0] i);
        return {16'hC0DE, 6'd0, s, i};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            mis_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Comparator: one-cycle latency, flags clear the cycle after Enable drops.
    always @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            bus.Cmp_valid <= 1'b0;
            bus.Cmp_error <= 1'b0;
        end else begin
            bus.Cmp_valid <= bus.Cmp_enable && (bus.Cmp_payload == golden(bus.Cmp_slot, bus.Cmp_counter));
            bus.Cmp_error <= bus.Cmp_enable && (bus.Cmp_payload != golden(bus.Cmp_slot, bus.Cmp_counter));
        end
    end

    // Monitor: pops scoreboard entries when the DUT pulses the comparator or finishes a chain.
    always @(negedge clk) begin
        if (Reset_n) begin
            if (bus.Cert_ready) ready_cycles++;
            if (bus.Cmp_enable) begin
                pulse_cnt++;
                if (pulse_q.size() == 0) begin
                    chk("unexpected_pulse", 32'(bus.Cmp_enable), 32'd0);
                end else begin
                    exp_p = pulse_q.pop_front();
                    chk("pulse_slot", 32'(bus.Cmp_slot), 32'(exp_p.slot));
                    chk("pulse_counter", 32'(bus.Cmp_counter), 32'(exp_p.idx));
                    chk("pulse_payload", bus.Cmp_payload, exp_p.payload);
                end
            end
            if (Done) begin
                done_cnt++;
                if (result_q.size() == 0) begin
                    chk("unexpected_done", 32'(Done), 32'd0);
                end else begin
                    exp_r = result_q.pop_front();
                    chk("done_pass", 32'(Pass), 32'(exp_r.pass));
                    chk("done_err_code", 32'(Err_code), 32'(exp_r.err));
                    chk("busy_low_at_done", 32'(Busy), 32'd0);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_chain(input logic [1:0] s);
        Start   = 1'b1;
        Slot_in = s;
        tick();
        Start   = 1'b0;
    endtask

    // Offers one chunk and waits (bounded) for Cert_ready; queues the expected pulse if it will be compared.
    task automatic send_chunk(input logic [1:0] s, input logic [7:0] i, input bit bad, input bit expect_cmp);
        logic [31:0] p;
        bit ok;
        p = golden(s, i) ^ (bad ? 32'h1 : 32'h0);
        bus.Cert_valid   = 1'b1;
        bus.Cert_payload = p;
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (bus.Cert_ready) begin
                ok = 1'b1;
                break;
            end
        end
        chk("chunk_accepted", 32'(ok), 32'd1);
        if (ok) begin
            if (expect_cmp) pulse_q.push_back('{s, i, p});
            tick();
        end
        bus.Cert_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int d0;
        bit ok;
        d0 = done_cnt;
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            #1;
            if (done_cnt != d0) begin
                ok = 1'b1;
                break;
            end
        end
        chk("done_within_budget", 32'(ok), 32'd1);
    endtask

    initial begin
        int p0;
        int r0;
        int d0;
        bit ok;
        Reset_n          = 1'b0;
        Start            = 1'b0;
        Abort            = 1'b0;
        Slot_in          = 2'd0;
        bus.Cert_valid   = 1'b0;
        bus.Cert_payload = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_done", 32'(Done), 32'd0);
        chk("rst_pass", 32'(Pass), 32'd0);
        chk("rst_err", 32'(Err_code), 32'd0);
        chk("rst_ready", 32'(bus.Cert_ready), 32'd0);
        chk("rst_enable", 32'(bus.Cmp_enable), 32'd0);
        chk("rst_counter", 32'(bus.Cmp_counter), 32'd0);
        chk("rst_payload", bus.Cmp_payload, 32'd0);
        Reset_n = 1'b1;
        tick();

        // Slot 0: six good chunks.
        p0 = pulse_cnt;
        result_q.push_back('{1'b1, ERR_OK});
        start_chain(SLOT_0);
        chk("t1_busy", 32'(Busy), 32'd1);
        for (int i = 1; i <= 6; i++) send_chunk(SLOT_0, 8'(i), 1'b0, 1'b1);
        wait_done(20);
        chk("t1_pulses", 32'(pulse_cnt - p0), 32'd6);
        tick();
        chk("t1_pass_held", 32'(Pass), 32'd1);
        chk("t1_err_held", 32'(Err_code), 32'd0);

        // Slot 1: third chunk mismatches.
        p0 = pulse_cnt;
        result_q.push_back('{1'b0, ERR_MISMATCH});
        start_chain(SLOT_1);
        chk("t2_pass_cleared", 32'(Pass), 32'd0);
        send_chunk(SLOT_1, 8'd1, 1'b0, 1'b1);
        send_chunk(SLOT_1, 8'd2, 1'b0, 1'b1);
        send_chunk(SLOT_1, 8'd3, 1'b1, 1'b1);
        wait_done(20);
        chk("t2_pulses", 32'(pulse_cnt - p0), 32'd3);
        r0 = ready_cycles;
        repeat (10) tick();
        chk("t2_no_ready_after", 32'(ready_cycles - r0), 32'd0);

        // Slot 3: rejected, Done two cycles after Start.
        p0 = pulse_cnt;
        result_q.push_back('{1'b0, ERR_BAD_SLOT});
        start_chain(SLOT_NONE);
        @(negedge clk);
        chk("t3_done_cycle1", 32'(Done), 32'd0);
        @(negedge clk);
        chk("t3_done_cycle2", 32'(Done), 32'd1);
        chk("t3_err", 32'(Err_code), 32'(ERR_BAD_SLOT));
        repeat (3) tick();
        chk("t3_pulses", 32'(pulse_cnt - p0), 32'd0);

        // Slot 2: Abort coincides with the second chunk transfer.
        p0 = pulse_cnt;
        result_q.push_back('{1'b0, ERR_ABORT});
        start_chain(SLOT_2);
        send_chunk(SLOT_2, 8'd1, 1'b0, 1'b1);
        bus.Cert_valid   = 1'b1;
        bus.Cert_payload = golden(SLOT_2, 8'd2);
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (bus.Cert_ready) begin
                ok = 1'b1;
                break;
            end
        end
        chk("t4_ready_for_chunk2", 32'(ok), 32'd1);
        Abort = 1'b1;
        tick();
        Abort          = 1'b0;
        bus.Cert_valid = 1'b0;
        wait_done(10);
        chk("t4_pulses", 32'(pulse_cnt - p0), 32'd1);

        // Abort during PULSE: enable must drop within that cycle.
        p0 = pulse_cnt;
        result_q.push_back('{1'b0, ERR_ABORT});
        start_chain(SLOT_0);
        send_chunk(SLOT_0, 8'd1, 1'b0, 1'b0);
        Abort = 1'b1;
        @(negedge clk);
        chk("t4b_enable_dropped", 32'(bus.Cmp_enable), 32'd0);
        chk("t4b_counter", 32'(bus.Cmp_counter), 32'd1);
        tick();
        Abort = 1'b0;
        wait_done(10);
        chk("t4b_pulses", 32'(pulse_cnt - p0), 32'd0);

        // No chunk after Start: timeout, or an indefinite WAIT without it.
`ifdef CERT_SEQ_TIMEOUT_EN
        r0 = ready_cycles;
        result_q.push_back('{1'b0, ERR_TIMEOUT});
        start_chain(SLOT_1);
        wait_done(40);
        chk("t5_wait_cycles", 32'(ready_cycles - r0), 32'(TO));
`else
        start_chain(SLOT_1);
        d0 = done_cnt;
        repeat (40) tick();
        chk("t5_no_done", 32'(done_cnt - d0), 32'd0);
        chk("t5_still_busy", 32'(Busy), 32'd1);
        chk("t5_still_ready", 32'(bus.Cert_ready), 32'd1);
        result_q.push_back('{1'b0, ERR_ABORT});
        Abort = 1'b1;
        tick();
        Abort = 1'b0;
        wait_done(10);
`endif

        // Reset while in CHECK, then a clean chain.
        start_chain(SLOT_0);
        send_chunk(SLOT_0, 8'd1, 1'b0, 1'b1);
        tick();
        Reset_n = 1'b0;
        #1;
        chk("t6_busy", 32'(Busy), 32'd0);
        chk("t6_done", 32'(Done), 32'd0);
        chk("t6_pass", 32'(Pass), 32'd0);
        chk("t6_err", 32'(Err_code), 32'd0);
        chk("t6_ready", 32'(bus.Cert_ready), 32'd0);
        chk("t6_enable", 32'(bus.Cmp_enable), 32'd0);
        chk("t6_counter", 32'(bus.Cmp_counter), 32'd0);
        chk("t6_slot", 32'(bus.Cmp_slot), 32'd0);
        chk("t6_payload", bus.Cmp_payload, 32'd0);
        @(negedge clk);
        Reset_n = 1'b1;
        tick();
        p0 = pulse_cnt;
        result_q.push_back('{1'b1, ERR_OK});
        start_chain(SLOT_1);
        for (int i = 1; i <= 4; i++) send_chunk(SLOT_1, 8'(i), 1'b0, 1'b1);
        wait_done(20);
        chk("t6_pulses", 32'(pulse_cnt - p0), 32'd4);

        repeat (2) tick();
        chk("queues_drained", 32'(pulse_q.size() + result_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
        $finish;
    end
endmodule
